// File: rtl/chan_emu_pkg.sv
// Shared constants and arithmetic helpers for the IQ loopback channel emulator.
// Functions are sized from the package W so every stage agrees on widths.
package chan_emu_pkg;

    localparam int W       = 12;
    localparam int NOISE_W = 6;
    localparam int GAIN_W  = 4;
    localparam int PROD_W  = W + 4;
    localparam int SUM_W   = W + 6;

    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;
    // Taps 16,14,13,11 of the right-shifting register sit at bits 0,2,3,5
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {^(cur & LFSR_TAPS), cur[15:1]};
    endfunction

    function automatic logic is_clip(input logic signed [SUM_W-1:0] v);
        return (v > SAT_MAX) || (v < SAT_MIN);
    endfunction

    function automatic logic signed [W-1:0] sat_w(input logic signed [SUM_W-1:0] v);
        logic signed [W-1:0] r;
        if (v > SAT_MAX) begin
            r = SAT_MAX[W-1:0];
        end else if (v < SAT_MIN) begin
            r = SAT_MIN[W-1:0];
        end else begin
            r = v[W-1:0];
        end
        return r;
    endfunction

    // Arithmetic shift floors; negative values with a remainder step back up by one
    function automatic logic signed [W-1:0] trunc0_div4(input logic signed [W-1:0] x);
        logic signed [W-1:0] q;
        q = x >>> 2;
        if (x[W-1] && (x[1:0] != 2'b00)) begin
            q = q + W'(1);
        end
        return q;
    endfunction

endpackage

// File: rtl/chan_delay_line.sv
// Circular IQ delay line: combinational read of the entry CH_DELAY valids back,
// zero until enough samples have been written since reset or the last delay change.
import chan_emu_pkg::*;

module chan_delay_line #(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_valid,
    input  logic signed [W-1:0] wr_i,
    input  logic signed [W-1:0] wr_q,
    input  logic [PTR_W-1:0]    delay,
    output logic signed [W-1:0] rd_i,
    output logic signed [W-1:0] rd_q
);

    logic [2*W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] fill_q, fill_d;
    logic [PTR_W-1:0] last_delay_q, last_delay_d;
    logic [PTR_W-1:0] fill_eff;
    logic [PTR_W-1:0] rd_ptr;
    logic [2*W-1:0]   rd_data;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        fill_d       = fill_q;
        last_delay_d = last_delay_q;
        rd_data      = '0;
        // A new delay value restarts the fill so stale alignment is never emitted
        fill_eff     = (delay != last_delay_q) ? '0 : fill_q;
        rd_ptr       = (wr_ptr_q >= delay) ? (wr_ptr_q - delay)
                                           : (wr_ptr_q + PTR_W'(DEPTH) - delay);
        if (wr_valid) begin
            if (fill_eff >= delay) begin
                rd_data = (delay == '0) ? {wr_i, wr_q} : mem[rd_ptr];
            end
            wr_ptr_d     = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            fill_d       = (fill_eff == PTR_W'(DEPTH - 1)) ? fill_eff : fill_eff + PTR_W'(1);
            last_delay_d = delay;
        end
    end

    assign rd_i = rd_data[2*W-1:W];
    assign rd_q = rd_data[W-1:0];

    always_ff @(posedge clk) begin
        if (rst_n && wr_valid) begin
            mem[wr_ptr_q] <= {wr_i, wr_q};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            last_delay_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            fill_q       <= fill_d;
            last_delay_q <= last_delay_d;
        end
    end

endmodule

// File: rtl/loopback_channel_emu.sv
// IQ channel emulator: delay, gain, LFSR noise, DC offset and saturation, two-cycle latency.
// Optional -90 degree output rotation is built when CHAN_IQ_ROTATE_EN is defined.
import chan_emu_pkg::*;

module loopback_channel_emu #(
    parameter int          DEPTH     = 16,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT,
    parameter int          DLY_W     = $clog2(DEPTH)
) (
    input  logic                 clk_32M768,
    input  logic                 rst_n_32M768,
    input  logic signed [W-1:0]  DAC_I,
    input  logic signed [W-1:0]  DAC_Q,
    input  logic                 DAC_valid,
    input  logic [GAIN_W-1:0]    CH_GAIN,
    input  logic [DLY_W-1:0]     CH_DELAY,
    input  logic [NOISE_W-1:0]   CH_NOISE_MASK,
    input  logic signed [W-1:0]  CH_DC_OFFSET,
`ifdef CHAN_IQ_ROTATE_EN
    input  logic                 CH_ROTATE,
`endif
    output logic signed [W-1:0]  ADC_I,
    output logic signed [W-1:0]  ADC_Q,
    output logic                 ADC_valid,
    output logic [15:0]          sat_count
);

    logic signed [W-1:0]      dl_i, dl_q;
    logic [15:0]              lfsr_q, lfsr_d;
    logic signed [PROD_W-1:0] s_i_q, s_i_d, s_q_q, s_q_d;
    logic [NOISE_W-1:0]       noise_i_q, noise_i_d, noise_q_q, noise_q_d;
    logic                     v1_q, v1_d, v2_q, v2_d;
    logic signed [W-1:0]      adc_i_q, adc_i_d, adc_q_q, adc_q_d;
    logic [15:0]              sat_count_q, sat_count_d;

    logic signed [PROD_W-1:0] div_i, div_q, gain_s;
    logic signed [SUM_W-1:0]  n_i, n_q, off_s, y_i, y_q, sel_i, sel_q;
    logic                     clip_any;

    chan_delay_line #(
        .DEPTH (DEPTH),
        .PTR_W (DLY_W)
    ) u_delay (
        .clk      (clk_32M768),
        .rst_n    (rst_n_32M768),
        .wr_valid (DAC_valid),
        .wr_i     (DAC_I),
        .wr_q     (DAC_Q),
        .delay    (CH_DELAY),
        .rd_i     (dl_i),
        .rd_q     (dl_q)
    );

    // Stage 1: gain, plus the LFSR snapshot that travels with the sample
    always_comb begin
        div_i     = PROD_W'(trunc0_div4(dl_i));
        div_q     = PROD_W'(trunc0_div4(dl_q));
        gain_s    = PROD_W'({1'b0, CH_GAIN});
        v1_d      = DAC_valid;
        s_i_d     = DAC_valid ? div_i * gain_s : '0;
        s_q_d     = DAC_valid ? div_q * gain_s : '0;
        noise_i_d = lfsr_q[NOISE_W-1:0];
        noise_q_d = lfsr_q[NOISE_W+7:8];
        lfsr_d    = DAC_valid ? lfsr_next(lfsr_q) : lfsr_q;
    end

    // Stage 2: noise, offset, optional rotation, clamp and clip counting
    always_comb begin
        n_i   = SUM_W'(noise_i_q & CH_NOISE_MASK);
        n_q   = SUM_W'(noise_q_q & CH_NOISE_MASK);
        off_s = SUM_W'(CH_DC_OFFSET);
        y_i   = SUM_W'(s_i_q) + n_i + off_s;
        y_q   = SUM_W'(s_q_q) + n_q + off_s;
        sel_i = y_i;
        sel_q = y_q;
`ifdef CHAN_IQ_ROTATE_EN
        if (CH_ROTATE) begin
            sel_i = y_q;
            sel_q = -y_i;
        end
`endif
        clip_any    = is_clip(sel_i) || is_clip(sel_q);
        v2_d        = v1_q;
        adc_i_d     = v1_q ? sat_w(sel_i) : '0;
        adc_q_d     = v1_q ? sat_w(sel_q) : '0;
        sat_count_d = sat_count_q;
        if (v1_q && clip_any && (sat_count_q != 16'hFFFF)) begin
            sat_count_d = sat_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_32M768) begin
        if (!rst_n_32M768) begin
            lfsr_q      <= LFSR_SEED;
            s_i_q       <= '0;
            s_q_q       <= '0;
            noise_i_q   <= '0;
            noise_q_q   <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            adc_i_q     <= '0;
            adc_q_q     <= '0;
            sat_count_q <= '0;
        end else begin
            lfsr_q      <= lfsr_d;
            s_i_q       <= s_i_d;
            s_q_q       <= s_q_d;
            noise_i_q   <= noise_i_d;
            noise_q_q   <= noise_q_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            adc_i_q     <= adc_i_d;
            adc_q_q     <= adc_q_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign ADC_I     = adc_i_q;
    assign ADC_Q     = adc_q_q;
    assign ADC_valid = v2_q;
    assign sat_count = sat_count_q;

endmodule
